// File: rtl/tune_sequencer_pkg.sv
// tune_pkg: shared types and constants for the Pong sound-event sequencer.
//   - state encoding of the sequencer FSM
//   - requester indices (bit position in Req/Grant/Pending)
//   - note/duration widths and the tune table (one row per requester)
//   - hi_idx(): index of the highest set bit, used for priority arbitration
package tune_pkg;

    localparam int TUNE_LEN = 4;
    localparam int NUM_REQ  = 3;
    localparam int STEP_W   = $clog2(TUNE_LEN);
    localparam int IDX_W    = $clog2(NUM_REQ);
    localparam int NOTE_W   = 4;
    localparam int DUR_W    = 4;
    localparam int ENTRY_W  = NOTE_W + DUR_W;

    localparam int REQ_HIT   = 0;
    localparam int REQ_WALL  = 1;
    localparam int REQ_SCORE = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        ARM   = 3'd2,
        WAIT  = 3'd3,
        NEXT  = 3'd4
    } state_e;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } entry_t;

    // Each byte is {note, duration}; duration 0 terminates a tune.
    // Row order follows the requester index (hit, wall, score).
    localparam logic [ENTRY_W-1:0] TUNE_TABLE [NUM_REQ][TUNE_LEN] = '{
        '{8'h11, 8'h00, 8'h00, 8'h00},
        '{8'h21, 8'h31, 8'h00, 8'h00},
        '{8'h41, 8'h51, 8'h61, 8'h72}
    };

    function automatic logic [IDX_W-1:0] hi_idx(input logic [NUM_REQ-1:0] v);
        hi_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) hi_idx = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/tune_sequencer_if.sv
// tune_sequencer_if: bundle between game logic / note player and the sequencer.
//   req    : per-requester one-cycle request pulses (bit0 hit, bit1 wall, bit2 score)
//   over   : note-player done level (1 = current note finished)
//   note   : note number to the player
//   dur    : note duration to the player
//   start  : one-cycle note start pulse
//   grant  : one-hot requester being served, 0 when idle
//   busy   : sequencer not idle
//   done   : one-cycle pulse on tune completion or abort
// master = sequencer side, slave = environment side.
interface tune_sequencer_if;
    import tune_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               over;
    logic [NOTE_W-1:0]  note;
    logic [DUR_W-1:0]   dur;
    logic               start;
    logic [NUM_REQ-1:0] grant;
    logic               busy;
    logic               done;

    modport master (input req, over, output note, dur, start, grant, busy, done);
    modport slave  (output req, over, input note, dur, start, grant, busy, done);

endinterface

// File: rtl/tune_sequencer_rom.sv
// tune_rom: combinational tune table lookup.
//   tune_i  : requester index selecting the tune
//   step_i  : entry within the tune
//   entry_o : {note, duration}; all-zero for an out-of-range tune index
module tune_rom
    import tune_pkg::*;
(
    input  logic [IDX_W-1:0]  tune_i,
    input  logic [STEP_W-1:0] step_i,
    output entry_t            entry_o
);

    always_comb begin
        entry_o = '0;
        if (int'(tune_i) < NUM_REQ) entry_o = entry_t'(TUNE_TABLE[tune_i][step_i]);
    end

endmodule

// File: rtl/tune_sequencer.sv
// tune_sequencer: latches sound requests, arbitrates by fixed priority
// (highest index wins) and plays the selected tune one note at a time,
// handshaking with the note player through start (pulse) / over (level).
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   seq_if : tune_sequencer_if.master (req/over in; note/dur/start/grant/busy/done out)
// Optional feature macro: TUNE_PREEMPT_EN -- at a note boundary a pending
// higher-priority request aborts the running tune.
module tune_sequencer
    import tune_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    tune_sequencer_if.master   seq_if
);

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  pend_q, pend_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [DUR_W-1:0]    dur_q, dur_d;

    logic [IDX_W-1:0]    win_idx, cur_idx, rom_idx;
    logic [STEP_W-1:0]   rom_step;
    logic                win_vld, last, preempt;
    entry_t              rom_e;

    assign win_vld = |pend_q;
    assign win_idx = hi_idx(pend_q);
    assign cur_idx = hi_idx(grant_q);

    // One ROM port: in IDLE it fetches entry 0 of the winner, otherwise the
    // entry after the current one (terminator check and next-note load).
    assign rom_idx  = (state_q == IDLE) ? win_idx : cur_idx;
    assign rom_step = (state_q == IDLE) ? '0 : step_q + STEP_W'(1);

    tune_rom u_rom (
        .tune_i  (rom_idx),
        .step_i  (rom_step),
        .entry_o (rom_e)
    );

    assign last = (step_q == STEP_W'(TUNE_LEN - 1)) || (rom_e.dur == '0);

`ifdef TUNE_PREEMPT_EN
    assign preempt = win_vld && (win_idx > cur_idx);
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        // Requests for the tune currently being served are dropped.
        pend_d  = pend_q | (seq_if.req & ~grant_q);
        grant_d = grant_q;
        step_d  = step_q;
        note_d  = note_q;
        dur_d   = dur_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = ISSUE;
                    grant_d = NUM_REQ'(1) << win_idx;
                    pend_d  = pend_d & ~grant_d;
                    step_d  = '0;
                    note_d  = rom_e.note;
                    dur_d   = rom_e.dur;
                end
            end
            ISSUE: state_d = ARM;
            // Player drops over once it has taken the note.
            ARM:   if (!seq_if.over) state_d = WAIT;
            WAIT:  if (seq_if.over)  state_d = NEXT;
            NEXT: begin
                if (last || preempt) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else begin
                    state_d = ISSUE;
                    step_d  = step_q + STEP_W'(1);
                    note_d  = rom_e.note;
                    dur_d   = rom_e.dur;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pend_q  <= '0;
            grant_q <= '0;
            step_q  <= '0;
            note_q  <= '0;
            dur_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            step_q  <= step_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
        end
    end

    assign seq_if.note  = note_q;
    assign seq_if.dur   = dur_q;
    assign seq_if.grant = grant_q;
    assign seq_if.start = (state_q == ISSUE);
    assign seq_if.busy  = (state_q != IDLE);
    assign seq_if.done  = (state_q == NEXT) && (last || preempt);

endmodule

// File: tb/tb_tune_sequencer.sv
module tb_tune_sequencer;
    import tune_pkg::*;

`ifdef TUNE_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic clk, rst;
    tune_sequencer_if ifc();

    tune_sequencer dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .seq_if (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference tunes, indexed by requester (hit, wall, score).
    int tb_note [3][4] = '{'{1, 0, 0, 0}, '{2, 3, 0, 0}, '{4, 5, 6, 7}};
    int tb_dur  [3][4] = '{'{1, 0, 0, 0}, '{1, 1, 0, 0}, '{1, 1, 1, 2}};
    int tb_len  [3]    = '{1, 2, 4};

    int n_cmp  = 0;
    int n_fail = 0;
    int lat    = 3;
    int n_done = 0;
    int pcnt   = 0;
    logic [3:0] obs_note[$];
    logic [3:0] obs_dur[$];
    logic [2:0] obs_grant[$];

    // Monitor: record every note start and every done pulse.
    always @(negedge clk) begin
        if (ifc.start) begin
            obs_note.push_back(ifc.note);
            obs_dur.push_back(ifc.dur);
            obs_grant.push_back(ifc.grant);
        end
        if (ifc.done) n_done++;
    end

    // Note player: drops over on start, raises it again lat cycles later.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            ifc.over = 1'b1;
            pcnt = 0;
        end else if (ifc.start) begin
            ifc.over = 1'b0;
            pcnt = lat;
        end else if (pcnt > 0) begin
            pcnt--;
            if (pcnt == 0) ifc.over = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_idle(input string nm);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 400) begin
            tick();
            n++;
            quiet = ifc.busy ? 0 : quiet + 1;
        end
        chk({nm, "_idle"}, quiet, 4);
    endtask

    function automatic int hi(input logic [2:0] v);
        int r = -1;
        for (int i = 0; i < 3; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Expected start stream: first tune truncated to fl notes, the rest complete.
    task automatic expect_tunes(input string nm, input int bs, input int bd,
                                input int ord[3], input int nt, input int fl);
        logic [3:0] en[$];
        logic [3:0] ed[$];
        logic [2:0] eg[$];
        for (int t = 0; t < nt; t++) begin
            int len = (t == 0) ? fl : tb_len[ord[t]];
            for (int k = 0; k < len; k++) begin
                en.push_back(4'(tb_note[ord[t]][k]));
                ed.push_back(4'(tb_dur[ord[t]][k]));
                eg.push_back(3'b001 << ord[t]);
            end
        end
        chk({nm, "_starts"}, obs_note.size() - bs, en.size());
        for (int k = 0; k < en.size() && bs + k < obs_note.size(); k++) begin
            chk($sformatf("%s_note%0d", nm, k), obs_note[bs+k], en[k]);
            chk($sformatf("%s_dur%0d", nm, k), obs_dur[bs+k], ed[k]);
            chk($sformatf("%s_grant%0d", nm, k), obs_grant[bs+k], eg[k]);
        end
        chk({nm, "_dones"}, n_done - bd, nt);
        chk({nm, "_grant_idle"}, ifc.grant, 0);
    endtask

    // r1 pulsed while idle; r2 pulsed in the WAIT cycle of the first note.
    task automatic run_case(input string nm, input logic [2:0] r1, input logic [2:0] r2,
                            input int ord[3], input int nt, input int fl);
        int bs = obs_note.size();
        int bd = n_done;
        int g = 0;
        ifc.req = r1;
        tick();
        ifc.req = '0;
        if (r2 != 0) begin
            while (obs_note.size() == bs && g < 30) begin
                tick();
                g++;
            end
            chk({nm, "_first_start"}, obs_note.size() > bs, 1);
            tick();
            ifc.req = r2;
            tick();
            ifc.req = '0;
        end
        wait_idle(nm);
        expect_tunes(nm, bs, bd, ord, nt, fl);
    endtask

    typedef struct {
        logic [2:0] r1;
        logic [2:0] r2;
        int         ord[3];
        int         nt;
        int         fl;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int bs, bd, g;

        vecs[0] = '{3'b001, 3'b000, '{0, 0, 0}, 1, 1};
        vecs[1] = '{3'b100, 3'b000, '{2, 0, 0}, 1, 4};
        vecs[2] = '{3'b011, 3'b000, '{1, 0, 0}, 2, 2};
        vecs[3] = '{3'b001, 3'b100, '{0, 2, 0}, 2, 1};
        vecs[4] = '{3'b010, 3'b100, '{1, 2, 0}, 2, PRE ? 1 : 2};
        vecs[5] = '{3'b001, 3'b001, '{0, 0, 0}, 1, 1};
        vecs[6] = '{3'b111, 3'b000, '{2, 1, 0}, 3, 4};
        vecs[7] = '{3'b110, 3'b001, '{2, 1, 0}, 3, 4};

        rst = 1'b1;
        ifc.req = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_start", ifc.start, 0);
        chk("rst_busy",  ifc.busy,  0);
        chk("rst_done",  ifc.done,  0);
        chk("rst_grant", ifc.grant, 0);
        chk("rst_note",  ifc.note,  0);
        chk("rst_dur",   ifc.dur,   0);

        // Cycle-exact single-note hit tune, player latency 3.
        lat = 3;
        ifc.req = 3'b001;
        tick();
        ifc.req = '0;
        chk("t1_start", ifc.start, 0);
        tick();
        chk("t2_start", ifc.start, 1);
        chk("t2_grant", ifc.grant, 1);
        chk("t2_note",  ifc.note,  1);
        chk("t2_dur",   ifc.dur,   1);
        chk("t2_busy",  ifc.busy,  1);
        tick();
        chk("t3_start", ifc.start, 0);
        tick();
        tick();
        chk("t5_done", ifc.done, 0);
        tick();
        chk("t6_done", ifc.done, 1);
        chk("t6_busy", ifc.busy, 1);
        tick();
        chk("t7_done",  ifc.done,  0);
        chk("t7_busy",  ifc.busy,  0);
        chk("t7_grant", ifc.grant, 0);
        chk("t7_note",  ifc.note,  1);
        wait_idle("t_end");

        for (int i = 0; i < 8; i++)
            run_case($sformatf("vec%0d", i), vecs[i].r1, vecs[i].r2, vecs[i].ord, vecs[i].nt, vecs[i].fl);

        // Reset during WAIT of score note 2, with a hit request pending.
        bs = obs_note.size();
        bd = n_done;
        g = 0;
        ifc.req = 3'b100;
        tick();
        ifc.req = '0;
        while (obs_note.size() < bs + 2 && g < 60) begin
            tick();
            g++;
        end
        chk("rm_second_start", obs_note.size(), bs + 2);
        ifc.req = 3'b001;
        tick();
        ifc.req = '0;
        rst = 1'b1;
        tick();
        chk("rm_start", ifc.start, 0);
        chk("rm_busy",  ifc.busy,  0);
        chk("rm_grant", ifc.grant, 0);
        chk("rm_note",  ifc.note,  0);
        chk("rm_dur",   ifc.dur,   0);
        chk("rm_done",  ifc.done,  0);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("rm_no_more_starts", obs_note.size(), bs + 2);
        chk("rm_no_done", n_done, bd);

        // Random rounds against the priority/preemption reference model.
        for (int r = 0; r < 12; r++) begin
            logic [2:0] m, r2, rem;
            int ord[3];
            int nt, first, fl;
            lat = $urandom_range(2, 5);
            m   = 3'($urandom_range(1, 7));
            r2  = 3'($urandom_range(0, 7));
            first = hi(m);
            rem = (m | r2) & ~(3'b001 << first);
            ord = '{0, 0, 0};
            ord[0] = first;
            nt = 1;
            for (int i = 2; i >= 0; i--) begin
                if (rem[i]) begin
                    ord[nt] = i;
                    nt++;
                end
            end
            fl = (PRE && ((r2 >> (first + 1)) != 0)) ? 1 : tb_len[first];
            run_case($sformatf("rnd%0d", r), m, r2, ord, nt, fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
